// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO display responder: register offsets,
// STATUS bit positions, conversion FSM states and the double-dabble step.
package mmio_pkg;

    localparam logic [1:0] REG_SW_DATA   = 2'd0;
    localparam logic [1:0] REG_LED_VALUE = 2'd1;
    localparam logic [1:0] REG_STATUS    = 2'd2;
    localparam logic [1:0] REG_BCD       = 2'd3;

    localparam int STATUS_BUSY_BIT       = 0;
    localparam int STATUS_SW_CHANGED_BIT = 1;

    localparam int CONV_ITERS = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } conv_state_t;

    // Layout: [19:16] hundreds, [15:12] tens, [11:8] units, [7:0] binary.
    function automatic logic [19:0] dd_step(input logic [19:0] sr);
        logic [19:0] adj;
        adj = sr;
        if (adj[11:8]  >= 4'd5) adj[11:8]  = adj[11:8]  + 4'd3;
        if (adj[15:12] >= 4'd5) adj[15:12] = adj[15:12] + 4'd3;
        if (adj[19:16] >= 4'd5) adj[19:16] = adj[19:16] + 4'd3;
        return {adj[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to BCD converter, one double-dabble iteration per
// clock; digit outputs change only when the final iteration completes.
module bin2bcd_seq
    import mmio_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       done,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] units
);

    logic [19:0] sr;
    logic [19:0] sr_next;
    logic [2:0]  iter;
    logic        active;

    assign sr_next = dd_step(sr);
    assign done    = active && (iter == 3'(CONV_ITERS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sr       <= '0;
            iter     <= '0;
            active   <= 1'b0;
            hundreds <= '0;
            tens     <= '0;
            units    <= '0;
        end else begin
            if (active) begin
                sr   <= sr_next;
                iter <= iter + 3'd1;
                if (done) begin
                    hundreds <= sr_next[19:16];
                    tens     <= sr_next[15:12];
                    units    <= sr_next[11:8];
                    active   <= 1'b0;
                end
            end
            // A start on the completing edge begins the next conversion at once.
            if (start) begin
                sr     <= {12'b0, bin};
                iter   <= '0;
                active <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_display_responder.sv
// Memory-mapped peripheral: debounced switch input, LED value register that
// is converted to BCD digits in the background, and a sticky change flag.
module mmio_display_responder
    import mmio_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MREQ,
    input  logic        WE,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    input  logic [7:0]  SW,
    output logic [7:0]  hundreds,
    output logic [7:0]  tens,
    output logic [7:0]  units,
    output logic        busy
);

    localparam int DW = $clog2(DEB_CYCLES + 1);

    // Bus handshake: a transfer happens in any cycle with MREQ=1; WE selects
    // a write (committed at the clock edge) or a combinational read on RD.
    logic [1:0] reg_sel;
    logic       bus_rd;
    logic       bus_wr;
    logic       led_wr;
    logic       status_wr;

    assign reg_sel   = A[3:2];
    assign bus_rd    = MREQ && !WE;
    assign bus_wr    = MREQ && WE;
    assign led_wr    = bus_wr && (reg_sel == REG_LED_VALUE);
    assign status_wr = bus_wr && (reg_sel == REG_STATUS);

    logic unused_bus_bits;
    assign unused_bus_bits = ^{A[31:4], A[1:0], WD[31:8]};

    logic [7:0]  sw_sync1;
    logic [7:0]  sw_sync2;
    logic [7:0]  sw_cand;
    logic [DW-1:0] deb_cnt;
    logic [7:0]  sw_data;
    logic        sw_changed;
    logic        sw_accept;

    assign sw_accept = (sw_sync2 == sw_cand) && (deb_cnt == DW'(DEB_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_sync1   <= '0;
            sw_sync2   <= '0;
            sw_cand    <= '0;
            deb_cnt    <= '0;
            sw_data    <= '0;
            sw_changed <= 1'b0;
        end else begin
            sw_sync1 <= SW;
            sw_sync2 <= sw_sync1;
            if (sw_sync2 != sw_cand) begin
                sw_cand <= sw_sync2;
                deb_cnt <= '0;
            end else if (deb_cnt != DW'(DEB_CYCLES)) begin
                deb_cnt <= deb_cnt + DW'(1);
            end
            if (sw_accept) sw_data <= sw_cand;
            // Setting outranks a simultaneous write-1-to-clear.
            if (sw_accept && (sw_cand != sw_data))
                sw_changed <= 1'b1;
            else if (status_wr && WD[STATUS_SW_CHANGED_BIT])
                sw_changed <= 1'b0;
        end
    end

    conv_state_t state;
    logic [7:0]  led_value;
    logic        pend_valid;
    logic        conv_done;
    logic        conv_start;
    logic [7:0]  start_val;
    logic [3:0]  h_nib;
    logic [3:0]  t_nib;
    logic [3:0]  u_nib;

    // led_value always holds the newest write, so it doubles as the pending value.
    assign start_val  = led_wr ? WD[7:0] : led_value;
    assign conv_start = ((state == ST_IDLE) && led_wr) ||
                        ((state == ST_CONV) && conv_done && (pend_valid || led_wr));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            led_value  <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (led_wr) led_value <= WD[7:0];
            case (state)
                ST_IDLE: begin
                    if (led_wr) state <= ST_CONV;
                end
                ST_CONV: begin
                    if (conv_done) begin
                        if (!(pend_valid || led_wr)) state <= ST_IDLE;
                        pend_valid <= 1'b0;
                    end else if (led_wr) begin
                        pend_valid <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk      (clk),
        .rst      (rst),
        .start    (conv_start),
        .bin      (start_val),
        .done     (conv_done),
        .hundreds (h_nib),
        .tens     (t_nib),
        .units    (u_nib)
    );

    assign busy     = (state == ST_CONV);
    assign hundreds = {4'b0, h_nib};
    assign tens     = {4'b0, t_nib};
    assign units    = {4'b0, u_nib};

    always_comb begin
        RD = '0;
        if (bus_rd) begin
            case (reg_sel)
                REG_SW_DATA:   RD[7:0] = sw_data;
                REG_LED_VALUE: RD[7:0] = led_value;
                REG_STATUS: begin
                    RD[STATUS_BUSY_BIT]       = busy;
                    RD[STATUS_SW_CHANGED_BIT] = sw_changed;
                end
                default:       RD[11:0] = {h_nib, t_nib, u_nib};
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_display_responder.sv
// Directed bench for mmio_display_responder: drivers push expected values,
// a negedge monitor pops and compares whenever a probe is presented.
module tb_mmio_display_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        MREQ;
    logic        WE;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;
    logic [7:0]  SW;
    logic [7:0]  hundreds;
    logic [7:0]  tens;
    logic [7:0]  units;
    logic        busy;

    logic [31:0] exp_rd_q[$];
    logic [31:0] exp_out_q[$];
    string       name_rd_q[$];
    string       name_out_q[$];
    logic        probe_rd;
    logic        probe_out;
    int          n_checks = 0;
    int          n_pass   = 0;

    mmio_display_responder #(.DEB_CYCLES(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .MREQ     (MREQ),
        .WE       (WE),
        .A        (A),
        .WD       (WD),
        .RD       (RD),
        .SW       (SW),
        .hundreds (hundreds),
        .tens     (tens),
        .units    (units),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Monitor: compares in the middle of the cycle, away from the active edge.
    always @(negedge clk) begin
        logic [31:0] e;
        logic [31:0] got;
        string       nm;
        if (probe_rd) begin
            n_checks++;
            if (exp_rd_q.size() == 0) begin
                $display("FAIL rd_queue: read presented with no expected entry, RD=%h", RD);
            end else begin
                e  = exp_rd_q.pop_front();
                nm = name_rd_q.pop_front();
                if (RD === e) n_pass++;
                else $display("FAIL %s: RD=%h expected %h", nm, RD, e);
            end
        end
        if (probe_out) begin
            got = {7'b0, busy, hundreds, tens, units};
            n_checks++;
            if (exp_out_q.size() == 0) begin
                $display("FAIL out_queue: probe with no expected entry, outputs=%h", got);
            end else begin
                e  = exp_out_q.pop_front();
                nm = name_out_q.pop_front();
                if (got === e) n_pass++;
                else $display("FAIL %s: {busy,h,t,u}=%h expected %h", nm, got, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        MREQ = 1'b1;
        WE   = 1'b1;
        A    = addr;
        WD   = data;
        tick();
        MREQ = 1'b0;
        WE   = 1'b0;
    endtask

    task automatic bus_read(input string nm, input logic [31:0] addr, input logic [31:0] exp);
        MREQ = 1'b1;
        WE   = 1'b0;
        A    = addr;
        exp_rd_q.push_back(exp);
        name_rd_q.push_back(nm);
        probe_rd = 1'b1;
        tick();
        probe_rd = 1'b0;
        MREQ = 1'b0;
    endtask

    task automatic probe_outputs(input string nm, input logic b,
                                 input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
        exp_out_q.push_back({7'b0, b, 4'b0, h, 4'b0, t, 4'b0, u});
        name_out_q.push_back(nm);
        probe_out = 1'b1;
        tick();
        probe_out = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; MREQ = 1'b0; WE = 1'b0; A = '0; WD = '0; SW = '0;
        probe_rd = 1'b0; probe_out = 1'b0;
        idle(3);
        rst = 1'b0;
        tick();

        // Reset state
        probe_outputs("reset_outputs", 1'b0, 4'd0, 4'd0, 4'd0);
        bus_read("reset_sw_data", 32'h0, 32'h0);
        bus_read("reset_led", 32'h4, 32'h0);
        bus_read("reset_status", 32'h8, 32'h0);
        bus_read("reset_bcd", 32'hC, 32'h0);

        // 0xFF -> 2,5,5 after exactly 8 busy cycles
        bus_write(32'h4, 32'hFF);
        probe_outputs("ff_first_busy", 1'b1, 4'd0, 4'd0, 4'd0);
        idle(6);
        probe_outputs("ff_last_busy", 1'b1, 4'd0, 4'd0, 4'd0);
        probe_outputs("ff_done", 1'b0, 4'd2, 4'd5, 4'd5);
        bus_read("ff_bcd", 32'hC, 32'h255);
        bus_read("ff_bcd_alias", 32'hABCD_EF0F, 32'h255);
        bus_read("ff_led", 32'h4, 32'hFF);

        // 0x7B with 0x07 written mid-conversion: chained, no busy gap
        bus_write(32'h4, 32'h7B);
        idle(2);
        bus_write(32'h4, 32'h07);
        bus_read("pend_led_readback", 32'h4, 32'h07);
        idle(3);
        probe_outputs("pend_first_last_busy", 1'b1, 4'd2, 4'd5, 4'd5);
        probe_outputs("pend_first_done", 1'b1, 4'd1, 4'd2, 4'd3);
        idle(6);
        probe_outputs("pend_second_last_busy", 1'b1, 4'd1, 4'd2, 4'd3);
        probe_outputs("pend_second_done", 1'b0, 4'd0, 4'd0, 4'd7);
        bus_read("pend_status_idle", 32'h8, 32'h0);

        // Switch debounce with short glitches, then a stable value
        SW = 8'hA5; idle(5);
        SW = 8'h00; idle(2);
        SW = 8'hA5; idle(8);
        SW = 8'h00; idle(3);
        bus_read("deb_glitch_sw", 32'h0, 32'h0);
        bus_read("deb_glitch_status", 32'h8, 32'h0);
        SW = 8'hA5;
        idle(10);
        bus_read("deb_early_sw", 32'h0, 32'h0);
        idle(20);
        bus_read("deb_stable_sw", 32'h0, 32'hA5);
        bus_read("deb_status_set", 32'h8, 32'h2);
        bus_write(32'h0, 32'hFF);
        bus_read("deb_ro_write_ignored", 32'h0, 32'hA5);
        bus_write(32'h8, 32'h1);
        bus_read("deb_w0_keeps_flag", 32'h8, 32'h2);
        bus_write(32'h8, 32'h2);
        bus_read("deb_w1c_cleared", 32'h8, 32'h0);

        // Reset during conversion with a pending value
        bus_write(32'h4, 32'h64);
        idle(1);
        bus_write(32'h4, 32'h11);
        idle(1);
        SW = 8'h00;
        do_reset();
        probe_outputs("rst_abort_outputs", 1'b0, 4'd0, 4'd0, 4'd0);
        bus_read("rst_led", 32'h4, 32'h0);
        bus_read("rst_sw_data", 32'h0, 32'h0);
        bus_read("rst_status", 32'h8, 32'h0);
        bus_write(32'h4, 32'h64);
        idle(7);
        probe_outputs("rst_reconv_last_busy", 1'b1, 4'd0, 4'd0, 4'd0);
        probe_outputs("rst_reconv_done", 1'b0, 4'd1, 4'd0, 4'd0);
        probe_outputs("rst_no_pending", 1'b0, 4'd1, 4'd0, 4'd0);

        // MREQ=0 write is ignored and RD stays 0
        MREQ = 1'b0; WE = 1'b1; A = 32'h4; WD = 32'h99;
        exp_rd_q.push_back(32'h0);
        name_rd_q.push_back("nomreq_rd_zero");
        probe_rd = 1'b1;
        tick();
        probe_rd = 1'b0; WE = 1'b0;
        probe_outputs("nomreq_no_conv", 1'b0, 4'd1, 4'd0, 4'd0);
        bus_read("nomreq_led_kept", 32'h4, 32'h64);

        // RD is 0 during a write cycle
        MREQ = 1'b1; WE = 1'b1; A = 32'h0; WD = 32'h0;
        exp_rd_q.push_back(32'h0);
        name_rd_q.push_back("write_cycle_rd_zero");
        probe_rd = 1'b1;
        tick();
        probe_rd = 1'b0; MREQ = 1'b0; WE = 1'b0;

        // 0x00 -> 0,0,0
        bus_write(32'h4, 32'h00);
        probe_outputs("zero_first_busy", 1'b1, 4'd1, 4'd0, 4'd0);
        idle(6);
        probe_outputs("zero_last_busy", 1'b1, 4'd1, 4'd0, 4'd0);
        probe_outputs("zero_done", 1'b0, 4'd0, 4'd0, 4'd0);
        bus_read("zero_bcd", 32'hC, 32'h000);

        idle(2);
        n_checks++;
        if (exp_rd_q.size() == 0 && exp_out_q.size() == 0) n_pass++;
        else $display("FAIL queues_drained: rd=%0d out=%0d entries left, required 0",
                      exp_rd_q.size(), exp_out_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mmio_display_responder.md
MMIO_DISPLAY_RESPONDER -- requirements
Module: mmio_display_responder

Interface
REQ-001 Parameter: DEB_CYCLES, default 16, number of consecutive stable clocks before a switch value is accepted.
REQ-002 Ports, in order:
- clk  input  1  system clock.
- rst  input  1  reset.
- MREQ  input  1  peripheral select from CPU data bus.
- WE  input  1  write enable.
- A  input  32  byte address.
- WD  input  32  write data.
- RD  output  32  read data.
- SW  input  8  raw asynchronous switches.
- hundreds  output  8  BCD digit.
- tens  output  8  BCD digit.
- units  output  8  BCD digit.
- busy  output  1  conversion in progress.
REQ-003 One clock; reset is synchronous and active-high.

Function
REQ-004 The block SHALL decode only A[3:2] when MREQ=1 and ignore A[31:4] and A[1:0].
REQ-005 The register map SHALL be:
- 0x0 SW_DATA: RO, debounced SW, zero-extended.
- 0x4 LED_VALUE: RW, 8 bits.
- 0x8 STATUS: bit0 busy (RO), bit1 sw_changed (sticky, write-1-to-clear).
- 0xC BCD: RO, [11:8]=hundreds, [7:4]=tens, [3:0]=units.
REQ-006 RD SHALL be combinational (same-cycle read) when MREQ=1 and WE=0; it SHALL be 0 otherwise, and unused bits SHALL read 0.
REQ-007 Writes SHALL take effect on the clk edge with MREQ=1 and WE=1; writes to RO fields are ignored; with MREQ=0 nothing changes.
REQ-008 SW SHALL pass a 2-flop synchronizer; a candidate counter SHALL accept the synchronized value into SW_DATA after DEB_CYCLES consecutive equal samples, and any change SHALL restart the count.
REQ-009 Acceptance of a value different from the current SW_DATA SHALL set sw_changed; if set and clear occur in the same cycle, set wins.
REQ-010 Conversion FSM states: IDLE, CONV.
- IDLE: a LED_VALUE write loads the shift register and enters CONV.
- CONV: exactly 8 double-dabble iterations, one per clk (add 3 to any BCD nibble >=5, then shift left 1).
REQ-011 busy SHALL be 1 in every cycle the FSM is in CONV.
REQ-012 hundreds/tens/units SHALL update atomically on the 8th CONV edge, 8 clocks after the write edge, with upper nibbles 0; they hold otherwise (no intermediate values visible).
REQ-013 A LED_VALUE write during CONV SHALL be stored in a one-deep pending register (latest write wins) without disturbing the current conversion.
REQ-014 On CONV completion with a pending value, the FSM SHALL go directly to CONV for the pending value (busy stays 1) and clear pending; otherwise it returns to IDLE.
REQ-015 LED_VALUE readback SHALL return the last written value, including a pending one.

Reset
REQ-016 On rst=1 at a clk edge, the following SHALL clear to 0: LED_VALUE, pending valid, SW_DATA, synchronizer flops, debounce counter, sw_changed, shift register, and all digit outputs. The FSM SHALL enter IDLE, and busy SHALL be 0 on the next cycle.
REQ-017 Reset during CONV SHALL abort the conversion without any digit update.

Structure
REQ-018 Package mmio_pkg SHALL hold the register offset constants, the FSM state enum typedef, and the STATUS bit positions.
REQ-019 The double-dabble datapath and its iteration counter SHALL be one sub-module, bin2bcd_seq (start, 8-bit in, done, three BCD nibbles); the top SHALL contain the decode, the debouncer, and the pending logic.
REQ-020 Target size: 120-400 RTL lines.

Verification
REQ-021 Write 0xFF to 0x4 -> busy=1 for 8 cycles, then hundreds=2, tens=5, units=5; read 0xC returns 0x255.
REQ-022 Write 0x7B, then write 0x07 at cycle 3 of CONV -> 1,2,3 after 8 clocks, then busy held with no gap, and 0,0,7 after 8 more clocks.
REQ-023 SW 0x00->0xA5 with glitches shorter than DEB_CYCLES -> SW_DATA stays 0 until 16 stable cycles, then reads 0xA5 with STATUS=0x2; write 0x2 to 0x8 -> STATUS=0x0.
REQ-024 Assert rst at cycle 4 of converting 0x64 -> digits 0,0,0, busy=0, pending cleared; a subsequent write of 0x64 gives 1,0,0.
REQ-025 MREQ=0 with WE=1 to 0x4 -> no state change and RD=0; write 0x00 -> 0,0,0 after 8 clocks.
